// File: rtl/labs_search_pkg.sv
// Shared types and constants for the LABS exhaustive search engine.
package labs_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CMP,
    DONE
  } state_t;

  // Word indices decoded from wbs_adr_i[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_LEN      = 3'd1;
  localparam logic [2:0] REG_START    = 3'd2;
  localparam logic [2:0] REG_END      = 3'd3;
  localparam logic [2:0] REG_BEST_E   = 3'd4;
  localparam logic [2:0] REG_BEST_SEQ = 3'd5;
  localparam logic [2:0] REG_COUNT    = 3'd6;
  localparam logic [2:0] REG_ICLR     = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;
  localparam int STAT_ERR    = 3;

  localparam int E_WIDTH_DEF = 16;
  localparam logic [E_WIDTH_DEF-1:0] E_SAT = '1;

  // Byte-lane merge of a Wishbone write into an existing register value.
  function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/labs_energy_unit.sv
// One LABS energy accumulator: adds C_k^2 for the presented k on each step,
// saturating at all-ones. valid is captured on clear and held for the batch.
module labs_energy_unit
  import labs_search_pkg::*;
#(
  parameter int MAX_SEQ_WIDTH = 16,
  parameter int E_WIDTH       = 16,
  parameter int NW            = $clog2(MAX_SEQ_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MAX_SEQ_WIDTH-1:0] seq,
  input  logic [NW-1:0]            n,
  input  logic [NW-1:0]            k,
  input  logic                     clear,
  input  logic                     step,
  input  logic                     valid_in,
  output logic [E_WIDTH-1:0]       energy,
  output logic                     valid
);

  localparam longint E_MAX = (longint'(1) << E_WIDTH) - 1;

  logic [MAX_SEQ_WIDTH-1:0] diff_bits;
  int     pop;
  int     c_k;
  longint term;
  longint sum;

  // Bit i of diff_bits is s_i XOR s_(i+k); only pairs with i+k < N count.
  always_comb begin
    diff_bits = seq ^ (seq >> k);
    pop = 0;
    for (int i = 0; i < MAX_SEQ_WIDTH; i++)
      if (diff_bits[i] && ((i + int'(k)) < int'(n))) pop++;
    c_k  = int'(n) - int'(k) - 2 * pop;
    term = longint'(c_k * c_k);
    sum  = longint'(energy) + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      energy <= '0;
      valid  <= valid_in;
    end else if (step) begin
      energy <= (sum > E_MAX) ? '1 : sum[E_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/labs_search_wb.sv
// Wishbone-mapped exhaustive LABS search with PARALLEL_UNITS energy units.
// Optional build macro LABS_SYM_SKIP_EN skips candidates with bit N-1 set.
module labs_search_wb
  import labs_search_pkg::*;
#(
  parameter int MAX_SEQ_WIDTH  = 16,
  parameter int E_WIDTH        = 16,
  parameter int PARALLEL_UNITS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int W  = MAX_SEQ_WIDTH;
  localparam int P  = PARALLEL_UNITS;
  localparam int NW = $clog2(W + 1);
  localparam logic [W:0]    ONE_X = 1;
  localparam logic [W-1:0]  ONE_W = 1;
  localparam logic [NW-1:0] ONE_N = 1;
  localparam logic [W:0]    P_X   = P;

  state_t state, state_nxt;

  logic              ack, req, wr, wr_ctrl, start_cmd, abort_cmd, iclr_cmd, busy;
  logic [2:0]        idx;
  logic [31:0]       len_r, rdata, dat_r, len_wr, start_wr, end_wr, count;
  logic [W-1:0]      start_r, end_r, end_lat, best_seq;
  logic [E_WIDTH-1:0] best_e;
  logic [W:0]        cur, cur_nxt, one_sh;
  logic [NW-1:0]     n_lat, k;
  logic              done, err, irq_en;
  logic              n_ok, range_bad;
  logic [W-1:0]      nmask, start_m, end_m;
  logic [W:0]        cand [P];
  logic [P-1:0]      cand_ok, unit_valid;
  logic [E_WIDTH-1:0] unit_e [P];
  logic              found;
  logic [E_WIDTH-1:0] min_e;
  logic [W-1:0]      min_seq;
  logic [31:0]       n_valid;
  logic              unused_bits;

  assign req       = wbs_stb_i & wbs_cyc_i & ~ack;
  assign wr        = req & wbs_we_i;
  assign idx       = wbs_adr_i[4:2];
  assign wr_ctrl   = wr && (idx == REG_CTRL) && wbs_sel_i[0];
  assign start_cmd = wr_ctrl && wbs_dat_i[CTRL_START];
  assign abort_cmd = wr_ctrl && wbs_dat_i[CTRL_ABORT];
  assign iclr_cmd  = wr && (idx == REG_ICLR) && wbs_sel_i[0] && wbs_dat_i[0];
  assign busy      = state inside {LOAD, RUN, CMP};

  assign len_wr   = wb_merge(len_r, wbs_dat_i, wbs_sel_i);
  assign start_wr = wb_merge(32'(start_r), wbs_dat_i, wbs_sel_i);
  assign end_wr   = wb_merge(32'(end_r), wbs_dat_i, wbs_sel_i);
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], start_wr[31:W], end_wr[31:W]};

  // Launch checks; the range bounds are masked to the low N bits.
  always_comb begin
    n_ok      = (len_r >= 32'd2) && (len_r <= 32'(W));
    one_sh    = ONE_X << len_r[NW-1:0];
    nmask     = one_sh[W-1:0] - ONE_W;
    start_m   = start_r & nmask;
    end_m     = end_r & nmask;
    range_bad = !n_ok || (start_m > end_m);
  end

  always_comb begin
    for (int u = 0; u < P; u++) begin
      cand[u]    = cur + u[W:0];
      cand_ok[u] = (cand[u] <= {1'b0, end_lat});
`ifdef LABS_SYM_SKIP_EN
      if (cand[u][n_lat - ONE_N]) cand_ok[u] = 1'b0;
`endif
    end
  end

  for (genvar u = 0; u < P; u++) begin : g_unit
    labs_energy_unit #(
      .MAX_SEQ_WIDTH(W),
      .E_WIDTH      (E_WIDTH),
      .NW           (NW)
    ) u_unit (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .seq     (cand[u][W-1:0]),
      .n       (n_lat),
      .k       (k),
      .clear   (state == LOAD),
      .step    (state == RUN),
      .valid_in(cand_ok[u]),
      .energy  (unit_e[u]),
      .valid   (unit_valid[u])
    );
  end

  // Strict '<' while scanning upward keeps the lowest unit index on ties.
  always_comb begin
    found   = 1'b0;
    min_e   = '1;
    min_seq = '0;
    n_valid = '0;
    for (int u = 0; u < P; u++) begin
      if (unit_valid[u]) begin
        n_valid = n_valid + 32'd1;
        if (!found || (unit_e[u] < min_e)) begin
          found   = 1'b1;
          min_e   = unit_e[u];
          min_seq = cand[u][W-1:0];
        end
      end
    end
    cur_nxt = cur + P_X;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL: begin
        rdata[STAT_BUSY]   = busy;
        rdata[STAT_DONE]   = done;
        rdata[STAT_IRQ_EN] = irq_en;
        rdata[STAT_ERR]    = err;
      end
      REG_LEN:      rdata = len_r;
      REG_START:    rdata[W-1:0] = start_r;
      REG_END:      rdata[W-1:0] = end_r;
      REG_BEST_E:   rdata[E_WIDTH-1:0] = best_e;
      REG_BEST_SEQ: rdata[W-1:0] = best_seq;
      REG_COUNT:    rdata = count;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_cmd) state_nxt = range_bad ? DONE : LOAD;
      LOAD: state_nxt = abort_cmd ? DONE : RUN;
      RUN: begin
        if (abort_cmd)               state_nxt = DONE;
        else if (k == n_lat - ONE_N) state_nxt = CMP;
      end
      CMP: begin
        if (abort_cmd || (cur_nxt > {1'b0, end_lat})) state_nxt = DONE;
        else                                          state_nxt = LOAD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack      <= 1'b0;
      dat_r    <= '0;
      len_r    <= '0;
      start_r  <= '0;
      end_r    <= '0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      best_e   <= '1;
      best_seq <= '0;
      count    <= '0;
      cur      <= '0;
      end_lat  <= '0;
      n_lat    <= '0;
      k        <= '0;
    end else begin
      ack   <= req;
      dat_r <= (req && !wbs_we_i) ? rdata : '0;
      if (wr_ctrl) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (wr && !busy) begin
        case (idx)
          REG_LEN:   len_r   <= len_wr;
          REG_START: start_r <= start_wr[W-1:0];
          REG_END:   end_r   <= end_wr[W-1:0];
          default: ;
        endcase
      end
      if (iclr_cmd) done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_cmd) begin
            done     <= 1'b0;
            err      <= range_bad;
            best_e   <= '1;
            best_seq <= '0;
            count    <= '0;
            cur      <= {1'b0, start_m};
            end_lat  <= end_m;
            n_lat    <= len_r[NW-1:0];
          end
        end
        LOAD: k <= ONE_N;
        RUN:  k <= k + ONE_N;
        CMP: begin
          // An abort landing on the compare cycle discards the in-flight batch.
          if (!abort_cmd) begin
            if (found && (min_e < best_e)) begin
              best_e   <= min_e;
              best_seq <= min_seq;
            end
            count <= count + n_valid;
            cur   <= cur_nxt;
          end
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat_r;
  assign irq_o     = done & irq_en;
  assign busy_o    = busy;

endmodule

// File: tb/tb_labs_search_wb.sv
// Directed and randomised bench for labs_search_wb, with a reference energy
// model and a read-data scoreboard queue.
module tb_labs_search_wb;
  import labs_search_pkg::*;

`ifdef LABS_SYM_SKIP_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, irq, busy;
  logic [31:0] dat_o;

  int errors = 0;
  int checks = 0;
  int unsigned cyc_cnt = 0;
  logic [31:0] exp_q[$];

  labs_search_wb dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .irq_o    (irq),
    .busy_o   (busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one Wishbone access; eff is the cycle count at the acked edge.
  task automatic wb_cycle(input logic wr, input logic [2:0] ri, input logic [31:0] wdata,
                          input logic [3:0] wsel, output logic [31:0] rd, output int unsigned eff);
    int n;
    n = 0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = wr;
    adr = {27'd0, ri, 2'b00}; dat_i = wdata; sel = wsel;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    rd = dat_o;
    eff = cyc_cnt;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("wb_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic wb_write(input logic [2:0] ri, input logic [31:0] wdata, input logic [3:0] wsel,
                          output int unsigned eff);
    logic [31:0] rd;
    wb_cycle(1'b1, ri, wdata, wsel, rd, eff);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] ri, input logic [31:0] exp);
    logic [31:0] rd;
    int unsigned eff;
    exp_q.push_back(exp);
    wb_cycle(1'b0, ri, 32'd0, 4'hF, rd, eff);
    check(tag, rd, exp_q.pop_front());
  endtask

  task automatic wait_irq(input int budget, output int unsigned at);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (irq !== 1'b1 && n < budget);
    at = cyc_cnt;
    check("irq_wait", {31'd0, irq}, 32'd1);
  endtask

  // Reference energy in the +1/-1 product form.
  function automatic int labs_energy(input int n, input int s);
    int e, c, a, b;
    e = 0;
    for (int k = 1; k < n; k++) begin
      c = 0;
      for (int i = 0; i < n - k; i++) begin
        a = ((s >> i) & 1) != 0 ? -1 : 1;
        b = ((s >> (i + k)) & 1) != 0 ? -1 : 1;
        c += a * b;
      end
      e += c * c;
    end
    if (e > 65535) e = 65535;
    return e;
  endfunction

  function automatic void model_search(input int n, input int st, input int en,
                                       output int best, output int bseq, output int cnt);
    int e;
    best = 65535; bseq = 0; cnt = 0;
    for (int c = st; c <= en; c++) begin
      if (SYM && (((c >> (n - 1)) & 1) != 0)) continue;
      cnt++;
      e = labs_energy(n, c);
      if (e < best) begin
        best = e;
        bseq = c;
      end
    end
  endfunction

  task automatic run_search(input int n, input int st, input int en, output int unsigned lat);
    int unsigned s, t, d;
    wb_write(REG_LEN, n, 4'hF, d);
    wb_write(REG_START, st, 4'hF, d);
    wb_write(REG_END, en, 4'hF, d);
    wb_write(REG_CTRL, 32'h5, 4'hF, s);
    wait_irq(3000, t);
    lat = t - s;
  endtask

  task automatic expect_result(input string tag, input int n, input int st, input int en,
                               input int unsigned lat);
    int best, bseq, cnt, r;
    model_search(n, st, en, best, bseq, cnt);
    r = en - st + 1;
    check({tag, "_latency"}, lat, ((r + 3) / 4) * (n + 1) + 1);
    wb_read({tag, "_best_e"}, REG_BEST_E, best);
    wb_read({tag, "_best_seq"}, REG_BEST_SEQ, bseq);
    wb_read({tag, "_count"}, REG_COUNT, cnt);
    wb_read({tag, "_status"}, REG_CTRL, 32'h6);
  endtask

  initial begin
    int unsigned lat, s, a, t;
    int n, st, en, nb, best, bseq, cnt;
    int err_n[3], err_st[3], err_en[3];

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_read("rst_status", REG_CTRL, 32'h0);
    wb_read("rst_best_e", REG_BEST_E, 32'hFFFF);
    @(posedge clk); #1;
    check("dat_idle_zero", dat_o, 32'd0);
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    wb_read("rst_best_seq", REG_BEST_SEQ, 32'h0);
    wb_read("rst_count", REG_COUNT, 32'h0);

    // N=3 full space, irq and ICLR
    run_search(3, 0, 7, lat);
    expect_result("n3", 3, 0, 7, lat);
    check("n3_best_e_const", 1, labs_energy(3, 1));
    wb_write(REG_ICLR, 32'h1, 4'hF, s);
    check("iclr_irq", {31'd0, irq}, 32'd0);
    wb_read("iclr_status", REG_CTRL, 32'h4);

    // Barker-13
    run_search(13, 32'hA60, 32'hA60, lat);
    expect_result("barker", 13, 32'hA60, 32'hA60, lat);
    wb_read("barker_e_const", REG_BEST_E, 32'd6);

    // Byte enables on LEN
    wb_write(REG_LEN, 32'h0000AB00, 4'b0010, s);
    wb_read("len_sel", REG_LEN, 32'h0000AB0D);

    // Illegal launches
    err_n  = '{5, 1, 17};
    err_st = '{9, 0, 0};
    err_en = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      run_search(err_n[i], err_st[i], err_en[i], lat);
      wb_read("err_status", REG_CTRL, 32'hE);
      wb_read("err_count", REG_COUNT, 32'h0);
      wb_read("err_best_e", REG_BEST_E, 32'hFFFF);
    end

    // Upper bits of START/END beyond N are ignored
    run_search(4, 32'h13, 32'hF5, lat);
    expect_result("mask", 4, 3, 5, lat);

    // Random small searches
    for (int i = 0; i < 3; i++) begin
      n  = $urandom_range(2, 6);
      st = $urandom_range(0, (1 << n) - 1);
      en = $urandom_range(st, (1 << n) - 1);
      run_search(n, st, en, lat);
      expect_result("rand", n, st, en, lat);
    end

    // Abort mid-run; LEN write while busy is dropped
    wb_write(REG_LEN, 12, 4'hF, s);
    wb_write(REG_START, 0, 4'hF, s);
    wb_write(REG_END, 4095, 4'hF, s);
    wb_write(REG_CTRL, 32'h5, 4'hF, s);
    repeat (100) @(posedge clk);
    wb_write(REG_LEN, 5, 4'hF, a);
    check("abort_busy_mid", {31'd0, busy}, 32'd1);
    repeat (100) @(posedge clk);
    wb_write(REG_CTRL, 32'h6, 4'hF, a);
    wait_irq(50, t);
    check("abort_busy", {31'd0, busy}, 32'd0);
    nb = (int'(a - s) - 1) / 13;
    model_search(12, 0, 4 * nb - 1, best, bseq, cnt);
    wb_read("abort_count", REG_COUNT, cnt);
    wb_read("abort_best_e", REG_BEST_E, best);
    wb_read("abort_best_seq", REG_BEST_SEQ, bseq);
    wb_read("abort_status", REG_CTRL, 32'h6);
    wb_read("abort_len", REG_LEN, 32'd12);

    // Reset mid-run
    wb_write(REG_LEN, 10, 4'hF, s);
    wb_write(REG_END, 1023, 4'hF, s);
    wb_write(REG_CTRL, 32'h5, 4'hF, s);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    check("mid_rst_ack", {31'd0, ack}, 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_read("mid_rst_status", REG_CTRL, 32'h0);
    wb_read("mid_rst_count", REG_COUNT, 32'h0);
    wb_read("mid_rst_best_e", REG_BEST_E, 32'hFFFF);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/labs_search_wb.md
Name: labs_search_wb

Overview:
- Parametrised, Wishbone-mapped exhaustive search engine for low-autocorrelation binary sequences (LABS).
- Software programs a sequence length N and a candidate range [START, END], then starts a search. PARALLEL_UNITS energy units each evaluate one candidate per batch, and the block keeps the minimum-energy sequence found.
- Sits behind the user-project Wishbone slave port and raises an interrupt on completion.

Parameters:
- MAX_SEQ_WIDTH, 16: maximum sequence length N; width of the candidate registers.
- E_WIDTH, 16: energy width; accumulated energy saturates at all-ones.
- PARALLEL_UNITS, 4: number of energy units (≥1); candidates evaluated per batch.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables, honoured on writes.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; decoded on [4:2] only.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  completion interrupt, level.
- busy_o  out  1  search in progress.

Behaviour:
- Reset: all outputs 0, all registers 0, state IDLE, BEST_E all-ones, BEST_SEQ 0.
- Wishbone handshake:
  - wbs_ack_o rises the cycle after (stb & cyc & !ack) and holds for exactly 1 cycle.
  - wbs_dat_o is valid with ack and is 0 otherwise.
  - Every access is acked, including writes that are ignored.
- Register map (byte offsets):
  - 0x00 CTRL. Write: b0 start (self-clearing), b1 abort, b2 irq_en. Read: b0 busy, b1 done, b2 irq_en, b3 err.
  - 0x04 LEN: N.
  - 0x08 START.
  - 0x0C END.
  - 0x10 BEST_E (RO).
  - 0x14 BEST_SEQ (RO).
  - 0x18 COUNT (RO): number of candidates evaluated.
  - 0x1C ICLR: writing 1 to b0 clears done.
- Writes to LEN, START and END while busy are ignored.
- CTRL.abort is honoured while busy: next state is DONE, best/count are kept.
- Encoding: bit i of a candidate = 1 means s_i = -1, otherwise +1. Only bits [N-1:0] of START and END are used.
- Energy definition:
  - C_k = (N-k) - 2*popcount(s_i XOR s_(i+k)) for i = 0 .. N-1-k.
  - E = sum of C_k^2 for k = 1 .. N-1.
  - Accumulation saturates at 2^E_WIDTH - 1.
- FSM:
  - IDLE, on start:
    - If N < 2, N > MAX_SEQ_WIDTH, or START > END: go to DONE with err=1 and COUNT=0.
    - Otherwise go to LOAD: clear best/count, set cur=START. The cur register is MAX_SEQ_WIDTH+1 bits, so it never wraps.
  - LOAD → RUN: unit u gets candidate cur+u; it is valid iff cur+u ≤ END.
  - RUN: k steps from 1 to N-1, one C_k^2 term per cycle; after N-1 cycles → CMP.
  - CMP (1 cycle):
    - Among valid units, pick the lowest E; a tie goes to the lowest unit index.
    - Replace best only if strictly lower, so the earliest sequence wins on ties.
    - COUNT += number of valid units.
    - cur += PARALLEL_UNITS. If cur > END → DONE, else → LOAD.
  - DONE (1 cycle): set done=1, then IDLE. irq_o = done & irq_en.
- Timing:
  - Batch latency is N+1 cycles (LOAD + N-1 RUN + CMP).
  - Total run time is ceil(R/P)*(N+1) + 1 cycles, where R = range size and P = PARALLEL_UNITS.
  - busy_o is high from LOAD through CMP.
- Edge cases:
  - Start while busy is ignored.
  - Start and ICLR written in the same cycle: the start takes effect and done clears.
  - A new start clears done and err.
  - Reset mid-run returns the block to the reset state immediately.

Optional Feature:
- LABS_SYM_SKIP_EN, defined: candidates with bit N-1 = 1 are marked invalid. This relies on complement symmetry; such candidates are not evaluated or counted, so the search space halves.
- Undefined: every candidate in range is evaluated.

Decomposition:
- Package labs_search_pkg holds:
  - FSM state enum (IDLE, LOAD, RUN, CMP, DONE).
  - Register offset constants.
  - CTRL/STATUS bit indices.
  - E_SAT constant.
- Sub-module labs_energy_unit (one instance per unit):
  - Inputs: seq, N, k, clear, step.
  - Outputs: saturating energy accumulator and valid flag.
  - Generated PARALLEL_UNITS times.

Test Plan:
- N=3, START=0, END=7, irq_en=1, start → BEST_E=1, BEST_SEQ=1, COUNT=8, done=1, irq_o=1; ICLR → irq_o=0.
- N=13, START=END=0xA60 (Barker-13) → BEST_E=6, BEST_SEQ=0xA60, COUNT=1, latency 15 cycles start-to-done.
- N=5, START=9, END=2 → err=1, done=1, COUNT=0, BEST_E=0xFFFF.
- N=12, range 0..4095, abort after 200 cycles → done=1, busy=0, COUNT equals batches completed × 4, LEN write during run ignored.
- Reset asserted mid-run with N=10 → all outputs 0 asynchronously; after release, STATUS reads 0.
- With LABS_SYM_SKIP_EN, N=3, range 0..7 → COUNT=4, BEST_E=1, BEST_SEQ=1.
